// File: rtl/per_pkg.sv
// Shared types and helpers for the peripheral-bus demultiplexer.
package per_pkg;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

  // Widest slave index needed for up to 16 slaves.
  localparam int IDX_MAX_W = 4;

  typedef struct packed {
    logic                 err;
    logic [IDX_MAX_W-1:0] idx;
  } per_out_entry_t;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/per_out_fifo.sv
// Small synchronous FIFO tracking outstanding transactions; head is visible combinationally.
module per_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      // NOTE: entries are cleared too, so the head never carries stale data after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/per_demux.sv
// Address-decoded demux from one peripheral master port to NB_SLAVES slaves,
// with in-order response steering and local error responses for unmapped addresses.
module per_demux
  import per_pkg::*;
#(
  parameter int          NB_SLAVES  = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter int          SEL_LSB    = 12,
  parameter int          MAX_OUT    = 4,
  parameter logic [31:0] ERR_RDATA  = ERR_RDATA_DEFAULT
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,

  input  logic                                 per_slave_req_i,
  input  logic [ADDR_WIDTH-1:0]                per_slave_add_i,
  input  logic                                 per_slave_we_i,
  input  logic [31:0]                          per_slave_wdata_i,
  input  logic [3:0]                           per_slave_be_i,
  output logic                                 per_slave_gnt_o,
  output logic                                 per_slave_r_valid_o,
  output logic                                 per_slave_r_opc_o,
  output logic [31:0]                          per_slave_r_rdata_o,

  output logic [NB_SLAVES-1:0]                 per_master_req_o,
  output logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] per_master_add_o,
  output logic [NB_SLAVES-1:0]                 per_master_we_o,
  output logic [NB_SLAVES-1:0][31:0]           per_master_wdata_o,
  output logic [NB_SLAVES-1:0][3:0]            per_master_be_o,
  input  logic [NB_SLAVES-1:0]                 per_master_gnt_i,
  input  logic [NB_SLAVES-1:0]                 per_master_r_valid_i,
  input  logic [NB_SLAVES-1:0]                 per_master_r_opc_i,
  input  logic [NB_SLAVES-1:0][31:0]           per_master_r_rdata_i
);

  localparam int IDX_W = clog2_min1(NB_SLAVES);
  localparam int HI_W  = ADDR_WIDTH - SEL_LSB;
  localparam int PAD   = 2 ** IDX_MAX_W;

  logic [HI_W-1:0]  sel_field;
  logic [IDX_W-1:0] idx;
  logic             mapped;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  per_out_entry_t   push_e;
  per_out_entry_t   head_e;

  logic [PAD-1:0]       rv_pad;
  logic [PAD-1:0]       opc_pad;
  logic [PAD-1:0][31:0] rdata_pad;

  // The whole field above SEL_LSB decides mapping, so aliases of a slave
  // window (e.g. 0x5000 with four slaves) are rejected instead of wrapping.
  assign sel_field = per_slave_add_i[ADDR_WIDTH-1:SEL_LSB];
  assign idx       = per_slave_add_i[SEL_LSB +: IDX_W];
  assign mapped    = (sel_field < HI_W'(NB_SLAVES));

  assign per_master_add_o   = {NB_SLAVES{per_slave_add_i}};
  assign per_master_we_o    = {NB_SLAVES{per_slave_we_i}};
  assign per_master_wdata_o = {NB_SLAVES{per_slave_wdata_i}};
  assign per_master_be_o    = {NB_SLAVES{per_slave_be_i}};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    per_master_req_o = '0;
    per_slave_gnt_o  = 1'b0;
    if (rst_ni) begin
      if (mapped) begin
        per_master_req_o[idx] = per_slave_req_i && !full;
        per_slave_gnt_o       = per_master_gnt_i[idx] && !full;
      end else begin
        per_slave_gnt_o = per_slave_req_i && !full;
      end
    end
  end

  assign push       = per_slave_gnt_o && per_slave_req_i;
  assign push_e.err = !mapped;
  assign push_e.idx = IDX_MAX_W'(idx);

  per_out_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH ($bits(per_out_entry_t))
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (push_e),
    .pop   (pop),
    .head  (head_e),
    .full  (full),
    .empty (empty)
  );

  // Zero-padded response buses let the full-width head index select directly.
  always_comb begin
    rv_pad    = '0;
    opc_pad   = '0;
    rdata_pad = '0;
    rv_pad[NB_SLAVES-1:0]    = per_master_r_valid_i;
    opc_pad[NB_SLAVES-1:0]   = per_master_r_opc_i;
    rdata_pad[NB_SLAVES-1:0] = per_master_r_rdata_i;
  end

  always_comb begin
    per_slave_r_valid_o = 1'b0;
    per_slave_r_opc_o   = 1'b0;
    per_slave_r_rdata_o = '0;
    if (!empty) begin
      if (head_e.err) begin
        per_slave_r_valid_o = 1'b1;
        per_slave_r_opc_o   = 1'b1;
        per_slave_r_rdata_o = ERR_RDATA;
      end else begin
        per_slave_r_valid_o = rv_pad[head_e.idx];
        per_slave_r_opc_o   = opc_pad[head_e.idx];
        per_slave_r_rdata_o = rdata_pad[head_e.idx];
      end
    end
  end

  assign pop = per_slave_r_valid_o;

endmodule

// File: tb/tb_per_demux.sv
// Directed, table-driven bench for per_demux with NB_SLAVES=4 and MAX_OUT=4.
module tb_per_demux;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              per_slave_req_i;
  logic [31:0]       per_slave_add_i;
  logic              per_slave_we_i;
  logic [31:0]       per_slave_wdata_i;
  logic [3:0]        per_slave_be_i;
  logic              per_slave_gnt_o;
  logic              per_slave_r_valid_o;
  logic              per_slave_r_opc_o;
  logic [31:0]       per_slave_r_rdata_o;
  logic [3:0]        per_master_req_o;
  logic [3:0][31:0]  per_master_add_o;
  logic [3:0]        per_master_we_o;
  logic [3:0][31:0]  per_master_wdata_o;
  logic [3:0][3:0]   per_master_be_o;
  logic [3:0]        per_master_gnt_i;
  logic [3:0]        per_master_r_valid_i;
  logic [3:0]        per_master_r_opc_i;
  logic [3:0][31:0]  per_master_r_rdata_i;

  int total = 0;
  int bad   = 0;

  per_demux #(
    .NB_SLAVES  (4),
    .ADDR_WIDTH (32),
    .SEL_LSB    (12),
    .MAX_OUT    (4),
    .ERR_RDATA  (32'hBADACCE5)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .per_slave_req_i      (per_slave_req_i),
    .per_slave_add_i      (per_slave_add_i),
    .per_slave_we_i       (per_slave_we_i),
    .per_slave_wdata_i    (per_slave_wdata_i),
    .per_slave_be_i       (per_slave_be_i),
    .per_slave_gnt_o      (per_slave_gnt_o),
    .per_slave_r_valid_o  (per_slave_r_valid_o),
    .per_slave_r_opc_o    (per_slave_r_opc_o),
    .per_slave_r_rdata_o  (per_slave_r_rdata_o),
    .per_master_req_o     (per_master_req_o),
    .per_master_add_o     (per_master_add_o),
    .per_master_we_o      (per_master_we_o),
    .per_master_wdata_o   (per_master_wdata_o),
    .per_master_be_o      (per_master_be_o),
    .per_master_gnt_i     (per_master_gnt_i),
    .per_master_r_valid_i (per_master_r_valid_i),
    .per_master_r_opc_i   (per_master_r_opc_i),
    .per_master_r_rdata_i (per_master_r_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // One record per clock cycle: inputs, then expected outputs seen in that cycle.
  // Slave 'sl' drives rdata/opc; every other slave drives their complements.
  typedef struct {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    int          sl;
    logic        opc;
    logic [31:0] rdata;
    logic        e_gnt;
    logic [3:0]  e_req;
    logic        e_rv;
    logic        e_opc;
    logic [31:0] e_rdata;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic req, input logic [31:0] add, input logic we,
                              input logic [3:0] gnt, input logic [3:0] rv, input int sl,
                              input logic opc, input logic [31:0] rdata,
                              input logic e_gnt, input logic [3:0] e_req, input logic e_rv,
                              input logic e_opc, input logic [31:0] e_rdata, input int e_cnt);
    vec_t v;
    v.req = req;  v.add = add;  v.we = we;  v.gnt = gnt;  v.rv = rv;  v.sl = sl;
    v.opc = opc;  v.rdata = rdata;
    v.e_gnt = e_gnt;  v.e_req = e_req;  v.e_rv = e_rv;  v.e_opc = e_opc;
    v.e_rdata = e_rdata;  v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic vec_t idle(input int cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, cnt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int i);
    per_slave_req_i   = v.req;
    per_slave_add_i   = v.add;
    per_slave_we_i    = v.we;
    per_slave_wdata_i = 32'hCAFE_0000 + 32'(i);
    per_slave_be_i    = 4'(i);
    per_master_gnt_i     = v.gnt;
    per_master_r_valid_i = v.rv;
    for (int k = 0; k < 4; k++) begin
      per_master_r_rdata_i[k] = (k == v.sl) ? v.rdata : ~v.rdata;
      per_master_r_opc_i[k]   = (k == v.sl) ? v.opc : ~v.opc;
    end
  endtask

  initial begin
    vec_t z;
    // Write to slave 1, response two cycles later.
    vecs.push_back(mk(1, 32'h0000_1004, 1, 4'b0010, 4'b0000, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0));
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0010, 1, 0, 32'h0, 0, 4'b0000, 1, 0, 32'h0, 1));
    vecs.push_back(idle(0));
    // Read from slave 3, data three cycles later.
    vecs.push_back(mk(1, 32'h0000_3000, 0, 4'b1000, 0, 0, 0, 0, 1, 4'b1000, 0, 0, 0, 0));
    vecs.push_back(idle(1));
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 0, 0, 0, 4'b1000, 3, 0, 32'h1234_5678, 0, 4'b0000, 1, 0, 32'h1234_5678, 1));
    vecs.push_back(idle(0));
    // Unmapped read: local grant, error response next cycle.
    vecs.push_back(mk(1, 32'h0000_5000, 0, 4'b1111, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 32'hBADACCE5, 1));
    vecs.push_back(idle(0));
    // Interleave slave 0, slave 2 (early r_valid ignored), unmapped; then push+pop.
    vecs.push_back(mk(1, 32'h0000_0010, 0, 4'b0001, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_2000, 1, 4'b0100, 4'b0100, 2, 0, 0, 1, 4'b0100, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h0000_7000, 0, 4'b0000, 4'b0100, 2, 0, 0, 1, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0101, 0, 0, 32'hA0A0_A0A0, 0, 4'b0000, 1, 0, 32'hA0A0_A0A0, 3));
    vecs.push_back(mk(1, 32'h0000_1000, 1, 4'b0010, 4'b0100, 2, 1, 32'hC2C2_C2C2, 1, 4'b0010, 1, 1, 32'hC2C2_C2C2, 2));
    vecs.push_back(mk(1, 32'h0000_1000, 0, 4'b0010, 0, 0, 0, 0, 1, 4'b0010, 1, 1, 32'hBADACCE5, 2));
    vecs.push_back(idle(2));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0010, 1, 0, 32'h1111_1111, 0, 4'b0000, 1, 0, 32'h1111_1111, 2));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0010, 1, 1, 32'h2222_2222, 0, 4'b0000, 1, 1, 32'h2222_2222, 1));
    vecs.push_back(idle(0));
    // Fill to MAX_OUT, fifth request stalls until one pop has taken effect.
    for (int c = 0; c < 4; c++)
      vecs.push_back(mk(1, 32'h0000_1000, 0, 4'b0010, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, c));
    vecs.push_back(mk(1, 32'h0000_1000, 0, 4'b0010, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4));
    vecs.push_back(mk(1, 32'h0000_1000, 0, 4'b0010, 4'b0010, 1, 0, 32'h3333_3333, 0, 4'b0000, 1, 0, 32'h3333_3333, 4));
    vecs.push_back(mk(1, 32'h0000_1000, 0, 4'b0010, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 3));
    for (int c = 4; c > 0; c--)
      vecs.push_back(mk(0, 0, 0, 0, 4'b0010, 1, 0, 32'h4444_0000 + 32'(c), 0, 4'b0000, 1, 0, 32'h4444_0000 + 32'(c), c));
    vecs.push_back(idle(0));

    // Reset state, with a request pending to show grants are held off.
    z = mk(1, 32'h0000_1000, 0, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    drive(z, 0);
    #2;
    check("reset gnt", 32'(per_slave_gnt_o), 32'd0);
    check("reset req", 32'(per_master_req_o), 32'd0);
    check("reset r_valid", 32'(per_slave_r_valid_o), 32'd0);
    check("reset rdata", per_slave_r_rdata_o, 32'd0);
    check("reset count", 32'(dut.u_fifo.count), 32'd0);
    drive(idle(0), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk_i);
      #1;
      drive(vecs[i], i);
      @(negedge clk_i);
      check($sformatf("v%0d gnt", i), 32'(per_slave_gnt_o), 32'(vecs[i].e_gnt));
      check($sformatf("v%0d req", i), 32'(per_master_req_o), 32'(vecs[i].e_req));
      check($sformatf("v%0d r_valid", i), 32'(per_slave_r_valid_o), 32'(vecs[i].e_rv));
      check($sformatf("v%0d count", i), 32'(dut.u_fifo.count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d add bcast", i), per_master_add_o[i % 4], vecs[i].add);
      check($sformatf("v%0d wdata bcast", i), per_master_wdata_o[(i + 1) % 4], 32'hCAFE_0000 + 32'(i));
      check($sformatf("v%0d be bcast", i), 32'(per_master_be_o[(i + 2) % 4]), 32'(i % 16));
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d opc", i), 32'(per_slave_r_opc_o), 32'(vecs[i].e_opc));
        check($sformatf("v%0d rdata", i), per_slave_r_rdata_o, vecs[i].e_rdata);
      end else if (vecs[i].e_cnt == 0) begin
        check($sformatf("v%0d empty rdata", i), per_slave_r_rdata_o, 32'd0);
      end
    end

    // Three outstanding to slave 0, then reset mid-flight.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      #1;
      drive(mk(1, 32'h0000_0000, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    end
    @(posedge clk_i);
    #1;
    check("pre-reset count", 32'(dut.u_fifo.count), 32'd3);
    per_master_r_valid_i = 4'b0001;
    rst_ni = 1'b0;
    #1;
    check("mid reset gnt", 32'(per_slave_gnt_o), 32'd0);
    check("mid reset req", 32'(per_master_req_o), 32'd0);
    check("mid reset r_valid", 32'(per_slave_r_valid_o), 32'd0);
    check("mid reset rdata", per_slave_r_rdata_o, 32'd0);
    check("mid reset opc", 32'(per_slave_r_opc_o), 32'd0);
    check("mid reset count", 32'(dut.u_fifo.count), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    per_slave_req_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      #1;
      per_master_r_valid_i = 4'b0001;
      @(negedge clk_i);
      check($sformatf("stale r_valid %0d", c), 32'(per_slave_r_valid_o), 32'd0);
      check($sformatf("stale count %0d", c), 32'(dut.u_fifo.count), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
